// File: rtl/ic_pkg.sv
// Shared types and default constants for the interrupt controller.
// The controller's optional APB priority readback is enabled by the IC_READBACK_EN macro.
package ic_pkg;

    typedef enum logic {
        IDLE         = 1'b0,
        WAIT_SERVICE = 1'b1
    } ic_state_e;

    localparam int IC_DEF_PERIPHERALS = 16;

endpackage

// File: rtl/ic_priority_arbiter.sv
// Combinational winner search: highest priority among active sources, lowest index on ties.
module ic_priority_arbiter
    import ic_pkg::*;
#(
    parameter int NO_OF_PERIPHERALS = IC_DEF_PERIPHERALS,
    parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS)
) (
    input  logic [NO_OF_PERIPHERALS-1:0] i_active,
    input  logic [WIDTH-1:0]             i_priority [NO_OF_PERIPHERALS],
    output logic [WIDTH-1:0]             o_index,
    output logic                         o_any_active
);

    logic [WIDTH-1:0] w_bestPriority;
    logic             w_found;

    // Strict greater-than keeps the earlier (lower) index when priorities tie.
    always_comb begin
        o_index        = '0;
        w_bestPriority = '0;
        w_found        = 1'b0;
        for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
            if (i_active[i] && (!w_found || (i_priority[i] > w_bestPriority))) begin
                o_index        = WIDTH'(i);
                w_bestPriority = i_priority[i];
                w_found        = 1'b1;
            end
        end
    end

    assign o_any_active = |i_active;

endmodule

// File: rtl/interrupt_controller.sv
// APB-programmable priority interrupt controller presenting one request at a time.
// Define IC_READBACK_EN to make the priority registers readable over APB.
module interrupt_controller
    import ic_pkg::*;
#(
    parameter int NO_OF_PERIPHERALS = IC_DEF_PERIPHERALS,
    parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS)
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic [WIDTH-1:0]             paddr,
    input  logic [WIDTH-1:0]             pwdata,
    output logic [WIDTH-1:0]             prdata,
    input  logic                         penable,
    input  logic                         pwrite,
    output logic                         pready,
    input  logic                         psel,
    input  logic [NO_OF_PERIPHERALS-1:0] interrupt_active,
    output logic [WIDTH-1:0]             interrupt_to_be_service,
    input  logic                         interrupt_serviced,
    output logic                         interrupt_valid
);

    logic [WIDTH-1:0] r_priority [NO_OF_PERIPHERALS];
    ic_state_e        r_state;
    ic_state_e        w_nextState;
    logic             r_valid;
    logic             w_nextValid;
    logic [WIDTH-1:0] r_index;
    logic [WIDTH-1:0] w_nextIndex;
    logic             w_write;
    logic [WIDTH-1:0] w_winIndex;
    logic             w_anyActive;

    assign pready  = psel & penable;
    assign w_write = pready & pwrite;

    // Addresses that match no register fall through the loop, so they are ignored.
    always_ff @(posedge pclk) begin
        if (!preset) begin
            for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
                r_priority[i] <= '0;
            end
        end else if (w_write) begin
            for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
                if (paddr == WIDTH'(i)) begin
                    r_priority[i] <= pwdata;
                end
            end
        end
    end

`ifdef IC_READBACK_EN
    logic w_read;

    assign w_read = pready & ~pwrite;

    always_comb begin
        prdata = '0;
        if (w_read) begin
            for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
                if (paddr == WIDTH'(i)) begin
                    prdata = r_priority[i];
                end
            end
        end
    end
`else
    assign prdata = '0;
`endif

    // Arbiter sees the registered priorities, so a same-cycle write only affects later arbitrations.
    ic_priority_arbiter #(
        .NO_OF_PERIPHERALS(NO_OF_PERIPHERALS),
        .WIDTH            (WIDTH)
    ) u_arbiter (
        .i_active    (interrupt_active),
        .i_priority  (r_priority),
        .o_index     (w_winIndex),
        .o_any_active(w_anyActive)
    );

    always_ff @(posedge pclk) begin
        if (!preset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_index <= '0;
        end else begin
            r_state <= w_nextState;
            r_valid <= w_nextValid;
            r_index <= w_nextIndex;
        end
    end

    // A presentation is only retired by interrupt_serviced; the source dropping does not matter.
    always_comb begin
        w_nextState = r_state;
        w_nextValid = r_valid;
        w_nextIndex = r_index;
        case (r_state)
            IDLE: begin
                if (w_anyActive) begin
                    w_nextState = WAIT_SERVICE;
                    w_nextValid = 1'b1;
                    w_nextIndex = w_winIndex;
                end
            end
            WAIT_SERVICE: begin
                if (interrupt_serviced) begin
                    w_nextState = IDLE;
                    w_nextValid = 1'b0;
                    w_nextIndex = '0;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextValid = 1'b0;
                w_nextIndex = '0;
            end
        endcase
    end

    assign interrupt_valid         = r_valid;
    assign interrupt_to_be_service = r_index;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios then randomized traffic
// against a behavioural model; prdata expectations follow IC_READBACK_EN.
module tb_interrupt_controller;

    localparam int N = 16;
    localparam int W = 4;

    logic         pclk = 1'b0;
    logic         preset;
    logic [W-1:0] paddr;
    logic [W-1:0] pwdata;
    logic [W-1:0] prdata;
    logic         penable;
    logic         pwrite;
    logic         pready;
    logic         psel;
    logic [N-1:0] interrupt_active;
    logic [W-1:0] interrupt_to_be_service;
    logic         interrupt_serviced;
    logic         interrupt_valid;

    int           totalCount = 0;
    int           badCount   = 0;

    logic [W-1:0] modelPri [N];
    bit           modelValid;
    int           modelIndex;

    interrupt_controller #(
        .NO_OF_PERIPHERALS(N),
        .WIDTH            (W)
    ) dut (
        .pclk                   (pclk),
        .preset                 (preset),
        .paddr                  (paddr),
        .pwdata                 (pwdata),
        .prdata                 (prdata),
        .penable                (penable),
        .pwrite                 (pwrite),
        .pready                 (pready),
        .psel                   (psel),
        .interrupt_active       (interrupt_active),
        .interrupt_to_be_service(interrupt_to_be_service),
        .interrupt_serviced     (interrupt_serviced),
        .interrupt_valid        (interrupt_valid)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Find the top priority among requesters, then the first requester holding it.
    function automatic int modelWinner(input logic [N-1:0] act);
        int topPri = -1;
        for (int i = 0; i < N; i++) begin
            if (act[i] && int'(modelPri[i]) > topPri) topPri = int'(modelPri[i]);
        end
        for (int i = 0; i < N; i++) begin
            if (act[i] && int'(modelPri[i]) == topPri) return i;
        end
        return 0;
    endfunction

    task automatic applyStimulus(input bit rstN, input bit sel, input bit en, input bit wr,
                                 input logic [W-1:0] addr, input logic [W-1:0] wdata,
                                 input logic [N-1:0] act, input bit svc);
        logic [W-1:0] expRd;
        preset             = rstN;
        psel               = sel;
        penable            = en;
        pwrite             = wr;
        paddr              = addr;
        pwdata             = wdata;
        interrupt_active   = act;
        interrupt_serviced = svc;
        #1;
        checkOutput("pready", 64'(pready), 64'(sel & en));
        expRd = '0;
`ifdef IC_READBACK_EN
        if (sel && en && !wr) expRd = modelPri[addr];
`endif
        checkOutput("prdata", 64'(prdata), 64'(expRd));
        if (!rstN) begin
            for (int i = 0; i < N; i++) modelPri[i] = '0;
            modelValid = 1'b0;
            modelIndex = 0;
        end else begin
            if (modelValid) begin
                if (svc) begin
                    modelValid = 1'b0;
                    modelIndex = 0;
                end
            end else if (act != '0) begin
                modelValid = 1'b1;
                modelIndex = modelWinner(act);
            end
            if (sel && en && wr) modelPri[addr] = wdata;
        end
        @(posedge pclk);
        #1;
        checkOutput("valid", 64'(interrupt_valid), 64'(modelValid));
        checkOutput("index", 64'(interrupt_to_be_service), 64'(modelIndex));
    endtask

    task automatic idleCycle(input logic [N-1:0] act, input bit svc);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, act, svc);
    endtask

    task automatic writePri(input logic [W-1:0] addr, input logic [W-1:0] data, input logic [N-1:0] act);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, addr, data, act, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) modelPri[i] = '1;
        modelValid = 1'b0;
        modelIndex = 0;
        @(negedge pclk);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("rstValid", 64'(interrupt_valid), 64'd0);
        checkOutput("rstIndex", 64'(interrupt_to_be_service), 64'd0);
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, W'(i), '0, '0, 1'b0);

        for (int i = 0; i < N; i++) writePri(W'(i), W'(i), '0);
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, W'(i), '0, '0, 1'b0);
        idleCycle(16'h8421, 1'b0);
        checkOutput("first15", 64'(interrupt_to_be_service), 64'd15);
        idleCycle(16'h0421, 1'b1);
        idleCycle(16'h0421, 1'b0);
        checkOutput("next10", 64'(interrupt_to_be_service), 64'd10);
        idleCycle(16'h0021, 1'b1);
        idleCycle(16'h0021, 1'b0);
        checkOutput("next5", 64'(interrupt_to_be_service), 64'd5);
        idleCycle(16'h0001, 1'b1);
        idleCycle(16'h0001, 1'b0);
        checkOutput("next0", 64'(interrupt_to_be_service), 64'd0);
        checkOutput("next0Valid", 64'(interrupt_valid), 64'd1);
        idleCycle('0, 1'b1);

        for (int i = 0; i < N; i++) writePri(W'(i), 4'd7, '0);
        idleCycle(16'h0030, 1'b0);
        checkOutput("tieLow", 64'(interrupt_to_be_service), 64'd4);
        idleCycle('0, 1'b1);

        idleCycle(16'h0200, 1'b0);
        checkOutput("present9", 64'(interrupt_to_be_service), 64'd9);
        for (int i = 0; i < 10; i++) idleCycle('0, 1'b0);
        checkOutput("hold9", 64'(interrupt_to_be_service), 64'd9);
        idleCycle('0, 1'b1);
        idleCycle('0, 1'b1);

        idleCycle(16'h1000, 1'b0);
        checkOutput("present12", 64'(interrupt_to_be_service), 64'd12);
        writePri(4'd3, 4'd15, 16'h1008);
        idleCycle(16'h1008, 1'b0);
        checkOutput("hold12", 64'(interrupt_to_be_service), 64'd12);
        idleCycle(16'h1008, 1'b1);
        idleCycle(16'h1008, 1'b0);
        checkOutput("after3", 64'(interrupt_to_be_service), 64'd3);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 16'h1008, 1'b0);
        checkOutput("midRstValid", 64'(interrupt_valid), 64'd0);
        checkOutput("midRstIndex", 64'(interrupt_to_be_service), 64'd0);
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, W'(i), '0, '0, 1'b0);

        // Mixed random traffic: APB reads/writes, request patterns, service pulses, rare resets.
        for (int c = 0; c < 3000; c++) begin
            bit           rstN;
            bit           sel;
            bit           en;
            bit           wr;
            logic [N-1:0] act;
            rstN = ($urandom_range(0, 149) != 0);
            sel  = ($urandom_range(0, 2) != 0);
            en   = ($urandom_range(0, 2) != 0);
            wr   = $urandom_range(0, 1) == 1;
            act  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            if ($urandom_range(0, 1) == 1) act = act & N'($urandom);
            applyStimulus(rstN, sel, en, wr, W'($urandom), W'($urandom), act, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
